// File: rtl/addsub_seq.sv
// addsub_seq: multi-cycle add/subtract unit.
// Operands are consumed CHUNK bits per clock, least significant chunk first,
// with the carry between chunks held in a register. The result is widened to
// 2*WIDTH bits and reported along with carry, overflow, zero and sign flags.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; outputs hold the last result
// RUN   | one chunk of the sum is produced per clock (N clocks)
// DONE  | done pulse; start here is accepted as in IDLE (back-to-back)

module addsub_seq #(
  parameter int WIDTH    = 32,
  parameter int CHUNK    = 8,
  parameter bit SIGN_EXT = 1'b1
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic                 start,
  input  logic                 op,
  input  logic                 use_cin,
  input  logic                 cin,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   result,
  output logic                 cout,
  output logic                 ovf,
  output logic                 zero,
  output logic                 neg
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  generate
    if ((CHUNK < 1) || (WIDTH % CHUNK != 0)) begin : g_bad_chunk
      $error("addsub_seq: WIDTH must be a non-zero multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;       // already inverted for subtract
  logic               carry_q;
  logic [KW-1:0]      k_q;
  logic [WIDTH-1:0]   sum_q;
  logic               op_q;

  int                 lo;
  logic [CHUNK-1:0]   a_chunk;
  logic [CHUNK-1:0]   b_chunk;
  logic [CHUNK-1:0]   s_chunk;
  logic               c_chunk;
  logic [WIDTH-1:0]   sum_full;
  logic               msb_cin;
  logic               last_chunk;
  logic [2*WIDTH-1:0] ext;

  // Chunk adder for the current index, plus the final result/flag values
  // that are only committed on the last chunk.
  always_comb begin
    lo                 = int'(k_q) * CHUNK;
    a_chunk            = a_q[lo +: CHUNK];
    b_chunk            = b_q[lo +: CHUNK];
    {c_chunk, s_chunk} = {1'b0, a_chunk} + {1'b0, b_chunk} + {{CHUNK{1'b0}}, carry_q};
    sum_full           = sum_q;
    sum_full[lo +: CHUNK] = s_chunk;
    // Sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly.
    msb_cin            = a_q[WIDTH-1] ^ b_q[WIDTH-1] ^ sum_full[WIDTH-1];
    last_chunk         = (k_q == KW'(N - 1));
    if (SIGN_EXT) begin
      ext = {{WIDTH{sum_full[WIDTH-1]}}, sum_full};
    end else if (op_q) begin
      // No borrow (cout=1) means a non-negative difference.
      ext = {{WIDTH{~c_chunk}}, sum_full};
    end else begin
      ext = {{(WIDTH-1){1'b0}}, c_chunk, sum_full};
    end
  end

  // Control FSM, operand capture, chunk sequencing and registered outputs.
  always_ff @(posedge clk) begin
    if (clr) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      zero    <= 1'b0;
      neg     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      sum_q   <= '0;
      op_q    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done <= 1'b0;
          if (start) begin
            a_q     <= a;
            b_q     <= op ? ~b : b;
            carry_q <= op ? ~(use_cin & cin) : (use_cin & cin);
            op_q    <= op;
            k_q     <= '0;
            sum_q   <= '0;
            busy    <= 1'b1;
            state   <= S_RUN;
          end else begin
            state   <= S_IDLE;
          end
        end
        S_RUN: begin
          sum_q   <= sum_full;
          carry_q <= c_chunk;
          k_q     <= k_q + 1'b1;
          if (last_chunk) begin
            k_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= ext;
            cout   <= c_chunk;
            ovf    <= msb_cin ^ c_chunk;
            zero   <= (sum_full == '0);
            neg    <= sum_full[WIDTH-1];
            state  <= S_DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
